// File: rtl/rtc_timekeeper_core.sv
// rtc_timekeeper_core: HH:MM:SS timekeeper with a 1 Hz prescaler, two debounced
// user keys, a RUN / SET_HOUR / SET_MIN / HOLD mode machine and packed-BCD
// display outputs in 12- or 24-hour format for the 7-segment scan driver.
module rtc_timekeeper_core #(
  parameter int TICK_DIV        = 65536,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_mode,
  input  logic       key_add,
  input  logic       hour12,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       pm,
  output logic [1:0] mode,
  output logic [1:0] field_blank,
  output logic       tick_out
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

  // Key index 1 is the mode key, index 0 is the add key.
  localparam int K_ADD  = 0;
  localparam int K_MODE = 1;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_HOLD     = 2'd3
  } mode_e;

  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [DW-1:0] db_cnt_q [2];
  logic [DW-1:0] db_cnt_d [2];
  logic [1:0]    level_q, level_d;
  logic [1:0]    press_q, press_d;

  mode_e         mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hour_q, hour_d;

  logic          sec_tick;
  logic          mode_press;
  logic          add_press;
  logic          blink_ph;
  logic [4:0]    hour_disp;

  // Converts a 0..59 binary value into two packed BCD digits.
  function automatic logic [7:0] bin2bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [5:0] rem;
    tens = 4'd0;
    rem  = v;
    for (int i = 0; i < 5; i++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

  assign mode_press = press_q[K_MODE];
  assign add_press  = press_q[K_ADD];

  // Two-flop synchroniser chain for the raw asynchronous keys.
  always_comb begin
    sync1_d = {key_mode, key_add};
    sync2_d = sync1_q;
  end

  // Stability counter per key: accept a new level after enough consecutive differing samples.
  always_comb begin
    level_d     = level_q;
    press_d     = 2'b00;
    db_cnt_d[0] = '0;
    db_cnt_d[1] = '0;
    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k] != level_q[k]) begin
        if (db_cnt_q[k] == DB_LAST) begin
          level_d[k] = sync2_q[k];
          press_d[k] = sync2_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + DW'(1);
        end
      end
    end
  end

  // Key synchroniser and debounce state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 2'b00;
      sync2_q     <= 2'b00;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      level_q     <= 2'b00;
      press_q     <= 2'b00;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
      level_q     <= level_d;
      press_q     <= press_d;
    end
  end

  // Second tick only fires while running, which freezes time during editing and hold.
  always_comb begin
    sec_tick = (presc_q == PRESC_LAST) && (mode_q == MODE_RUN);
  end

  // Prescaler wraps every TICK_DIV cycles, parked at zero in HOLD and cleared on entry to HOLD.
  always_comb begin
    presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
    if ((mode_q == MODE_HOLD) || (mode_press && (mode_q == MODE_SET_MIN))) begin
      presc_d = '0;
    end
  end

  // Mode sequence advances on each accepted mode-key press.
  always_comb begin
    mode_d = mode_q;
    if (mode_press) begin
      case (mode_q)
        MODE_RUN:      mode_d = MODE_SET_HOUR;
        MODE_SET_HOUR: mode_d = MODE_SET_MIN;
        MODE_SET_MIN:  mode_d = MODE_HOLD;
        MODE_HOLD:     mode_d = MODE_RUN;
        default:       mode_d = MODE_RUN;
      endcase
    end
  end

  // Time counters: ripple-carry on second ticks, plus field edits where mode beats add.
  always_comb begin
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    if (sec_tick) begin
      if (sec_q == 6'd59) begin
        sec_d = '0;
        if (min_q == 6'd59) begin
          min_d  = '0;
          hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
    if (mode_press) begin
      if (mode_q == MODE_SET_MIN) begin
        sec_d = '0;
      end
    end else if (add_press) begin
      if (mode_q == MODE_SET_HOUR) begin
        hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
      end else if (mode_q == MODE_SET_MIN) begin
        min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
      end
    end
  end

  // Mode FSM, prescaler and time registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q  <= MODE_RUN;
      presc_q <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
    end else begin
      mode_q  <= mode_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
    end
  end

  // 12-hour mapping and blink phase for the field being edited.
  always_comb begin
    if (hour12 && ((hour_q == 5'd0) || (hour_q == 5'd12))) begin
      hour_disp = 5'd12;
    end else if (hour12 && (hour_q > 5'd12)) begin
      hour_disp = hour_q - 5'd12;
    end else begin
      hour_disp = hour_q;
    end
    blink_ph = (presc_q < PRESC_HALF);
  end

  // Display outputs are combinational from the registered state.
  always_comb begin
    hour_bcd       = bin2bcd({1'b0, hour_disp});
    min_bcd        = bin2bcd(min_q);
    sec_bcd        = bin2bcd(sec_q);
    pm             = hour12 && (hour_q >= 5'd12);
    mode           = mode_q;
    field_blank[1] = (mode_q == MODE_SET_HOUR) && !blink_ph;
    field_blank[0] = (mode_q == MODE_SET_MIN) && !blink_ph;
    tick_out       = sec_tick;
  end

endmodule
